tlb_op_ctrl: RTL and testbench
==============================

// Module: tlb_op_ctrl
// PURPOSE
// Initiator side of the TLB maintenance interface. Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB from the pipeline onto the TLB
// write, read, s1-search and invtlb ports, and returns results for the CSR file to commit. Sits between EX/MEM and the TLB;
// borrows the shared s1 search port only while it owns it.
// PARAMETERS
// TLBNUM  16  TLB entries; power of two, 4..64. IDXW = $clog2(TLBNUM).
// PORTS
// clk             in   1     clock
// resetn          in   1     async active-low reset
// req_valid       in   1     op request
// req_ready       out  1     high only in IDLE
// req_op          in   3     0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 illegal
// req_inv_op      in   5     invtlb op
// req_inv_asid    in   10    invtlb asid (rj)
// req_inv_va      in   32    invtlb va (rk); vppn = va[31:13]
// csr_tlbidx      in   32    [IDXW-1:0] index, [29:24] PS, [31] NE
// csr_tlbehi_vppn in   19    TLBEHI.VPPN
// csr_asid        in   10    ASID.ASID
// csr_tlbelo0/1   in   32    [0]V [1]D [3:2]PLV [5:4]MAT [6]G [27:8]PPN
// csr_refill      in   1     ESTAT.Ecode==0x3F
// s1_own          out  1     top muxes s1_* from this block when high
// s1_vppn/s1_asid out  19/10 search key; s1_va_bit12 out 1, always 0
// s1_found/s1_index in 1/IDXW search result
// invtlb_valid    out  1     one-cycle invtlb pulse
// invtlb_op       out  5     invtlb opcode
// we/w_index      out  1/IDXW one-cycle write pulse, target entry
// w_bus           out  89    {e,vppn,ps,asid,g, ppn0,plv0,mat0,d0,v0, ppn1,plv1,mat1,d1,v1}
// r_index/r_bus   out/in IDXW/89  read index, read data (same packing)
// resp_valid/resp_ready out/in 1  result handshake
// resp_op/resp_err  out 3/1  op echoed; err = illegal op or invtlb op>6
// resp_found/resp_index out 1/IDXW  SRCH hit/index; RD: found=r_e
// resp_entry      out  89   RD data; zero for other ops
// BEHAVIOUR
// - FSM IDLE -> EXEC -> RESP -> IDLE. Accept on req_valid&req_ready; all req_* and csr_* latched into operand regs at accept.
// - EXEC lasts exactly one cycle. Port drive per op:
//   SRCH: s1_own=1, key = latched vppn/asid; found/index captured at EXEC end.
//   RD: r_index = latched index; r_bus captured.
//   WR: we=1, w_index = latched index.
//   FILL: we=1, w_index = fill index sampled at accept.
//   INV: s1_own=1, s1_vppn=va[31:13], s1_asid=inv_asid, invtlb_valid=1 iff inv_op<=6.
// - w_bus: e = refill|~NE, ps = PS, g = elo0.G&elo1.G, vppn/asid from CSRs, lo fields from elo0/elo1.
// - Illegal op/inv_op: no TLB port asserted; resp_err=1.
// - RESP: resp_valid=1, resp_* stable until resp_ready; handshake -> IDLE.
//   Min 3 cycles/op; no overlap.
// - we, invtlb_valid, s1_own are never high outside EXEC; we and invtlb_valid never high together.
// - Fill counter: IDXW-bit, +1 every cycle, wraps TLBNUM-1 -> 0.
// - Reset (any state, incl. mid-EXEC): state=IDLE, all outputs 0 except req_ready=1, counter=0. A write not yet clocked is dropped.
// CONFIGURATION
// TLB_FILL_LFSR_EN defined: fill index = lfsr[IDXW-1:0]. LFSR is 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, steps every cycle.
// Not defined: fill index from the wrap counter.
// TESTING
// - WR: idx 5, vppn 19'h12345, PS 12, NE 0, asid 3 -> we one cycle; w_index 5, e=1. Then RD idx 5 -> resp_entry = w_bus, resp_found=1.
// - SRCH: after the WR above, key vppn 19'h12345/asid 3 -> found=1, index 5. Key vppn 19'h12346 -> found=0.
// - FILL, counter mode: accept at counter 7 then 11 -> w_index 7 then 11. NE=1 with refill=1 -> e=1.
// - INV op 5, asid 3, va 32'h2468_A000 -> invtlb_valid one cycle, op 5, s1_vppn 19'h12345.
//   op 9 -> no pulse, resp_err=1.
// - resp_ready low 4 cycles -> resp stable, req_ready 0. resetn low during EXEC of WR -> no we edge, IDLE, req_ready=1.
// - TLB_FILL_LFSR_EN: first fill after reset (accept at cycle 0) -> w_index = 16'hACE1[IDXW-1:0].

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: initiator side of the TLB maintenance interface.
// Runs one TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB at a time onto the TLB write,
// read, s1-search and invtlb ports, then holds the result for the CSR file.
// Build option: TLB_FILL_LFSR_EN takes the TLBFILL index from a 16-bit LFSR
// instead of the free-running wrap counter.
//
// state | meaning
// IDLE  | req_ready high; request operands and CSRs latched on accept
// EXEC  | exactly one cycle driving the TLB ports for the latched op
// RESP  | resp_valid high, resp_* held until resp_ready
module tlb_op_ctrl #(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [4:0]      req_inv_op,
    input  logic [9:0]      req_inv_asid,
    input  logic [31:0]     req_inv_va,
    input  logic [31:0]     csr_tlbidx,
    input  logic [18:0]     csr_tlbehi_vppn,
    input  logic [9:0]      csr_asid,
    input  logic [31:0]     csr_tlbelo0,
    input  logic [31:0]     csr_tlbelo1,
    input  logic            csr_refill,
    output logic            s1_own,
    output logic [18:0]     s1_vppn,
    output logic [9:0]      s1_asid,
    output logic            s1_va_bit12,
    input  logic            s1_found,
    input  logic [IDXW-1:0] s1_index,
    output logic            invtlb_valid,
    output logic [4:0]      invtlb_op,
    output logic            we,
    output logic [IDXW-1:0] w_index,
    output logic [88:0]     w_bus,
    output logic [IDXW-1:0] r_index,
    input  logic [88:0]     r_bus,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [2:0]      resp_op,
    output logic            resp_err,
    output logic            resp_found,
    output logic [IDXW-1:0] resp_index,
    output logic [88:0]     resp_entry
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;
    localparam logic [IDXW-1:0] IDX_ONE = IDXW'(1);

    state_t state, state_nx;

    logic [2:0]      op_q;
    logic [4:0]      inv_op_q;
    logic [9:0]      inv_asid_q;
    logic [18:0]     inv_vppn_q;
    logic [IDXW-1:0] idx_q;
    logic [5:0]      ps_q;
    logic            ne_q;
    logic [18:0]     vppn_q;
    logic [9:0]      asid_q;
    logic            g_q;
    logic [25:0]     lo0_q, lo1_q;
    logic            refill_q;
    logic [IDXW-1:0] fill_idx_q;
    logic [IDXW-1:0] fill_cnt;
    logic [IDXW-1:0] fill_src;

    logic [2:0]      resp_op_q;
    logic            resp_err_q;
    logic            resp_found_q;
    logic [IDXW-1:0] resp_index_q;
    logic [88:0]     resp_entry_q;

    logic            op_illegal;
    logic            accept;
    logic [88:0]     w_bus_full;

    // Fields of TLBELO that never reach the TLB entry.
    logic unused_bits;
    assign unused_bits = ^{csr_tlbidx[30], csr_tlbidx[23:IDXW], csr_tlbelo0[31:28],
                           csr_tlbelo0[7], csr_tlbelo1[31:28], csr_tlbelo1[7],
                           req_inv_va[12:0]};

    // TLBELO -> entry lo half: {ppn, plv, mat, d, v}
    function automatic logic [25:0] lo_fields(input logic [31:0] elo);
        return {elo[27:8], elo[3:2], elo[5:4], elo[1], elo[0]};
    endfunction

    assign accept      = (state == ST_IDLE) && req_valid;
    assign op_illegal  = (op_q > OP_INV) || ((op_q == OP_INV) && (inv_op_q > 5'd6));
    // A refill-exception write always creates a valid entry regardless of NE.
    assign w_bus_full  = {refill_q | ~ne_q, vppn_q, ps_q, asid_q, g_q, lo0_q, lo1_q};
    assign s1_va_bit12 = 1'b0;

    // Fill index source: free-running counter wrapping at TLBNUM-1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fill_cnt <= '0;
        else         fill_cnt <= fill_cnt + IDX_ONE;
    end

`ifdef TLB_FILL_LFSR_EN
    logic [15:0] lfsr;
    logic        unused_cnt;
    assign unused_cnt = ^fill_cnt;
    assign fill_src   = lfsr[IDXW-1:0];

    // Fibonacci LFSR, taps 16,14,13,11, stepping every cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= 16'hACE1;
        else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`else
    assign fill_src = fill_cnt;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // Operand capture at accept; later CSR changes do not affect the op in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            idx_q      <= '0;
            ps_q       <= '0;
            ne_q       <= 1'b0;
            vppn_q     <= '0;
            asid_q     <= '0;
            g_q        <= 1'b0;
            lo0_q      <= '0;
            lo1_q      <= '0;
            refill_q   <= 1'b0;
            fill_idx_q <= '0;
        end else if (accept) begin
            op_q       <= req_op;
            inv_op_q   <= req_inv_op;
            inv_asid_q <= req_inv_asid;
            inv_vppn_q <= req_inv_va[31:13];
            idx_q      <= csr_tlbidx[IDXW-1:0];
            ps_q       <= csr_tlbidx[29:24];
            ne_q       <= csr_tlbidx[31];
            vppn_q     <= csr_tlbehi_vppn;
            asid_q     <= csr_asid;
            g_q        <= csr_tlbelo0[6] & csr_tlbelo1[6];
            lo0_q      <= lo_fields(csr_tlbelo0);
            lo1_q      <= lo_fields(csr_tlbelo1);
            refill_q   <= csr_refill;
            fill_idx_q <= fill_src;
        end
    end

    // Result capture at the end of EXEC; held unchanged through RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_op_q    <= '0;
            resp_err_q   <= 1'b0;
            resp_found_q <= 1'b0;
            resp_index_q <= '0;
            resp_entry_q <= '0;
        end else if (state == ST_EXEC) begin
            resp_op_q    <= op_q;
            resp_err_q   <= op_illegal;
            resp_found_q <= 1'b0;
            resp_index_q <= '0;
            resp_entry_q <= '0;
            if (!op_illegal) begin
                case (op_q)
                    OP_SRCH: begin
                        resp_found_q <= s1_found;
                        resp_index_q <= s1_index;
                    end
                    OP_RD: begin
                        resp_found_q <= r_bus[88];
                        resp_index_q <= idx_q;
                        resp_entry_q <= r_bus;
                    end
                    OP_WR:   resp_index_q <= idx_q;
                    OP_FILL: resp_index_q <= fill_idx_q;
                    default: ;
                endcase
            end
        end
    end

    assign resp_valid = (state == ST_RESP);
    assign resp_op    = resp_op_q;
    assign resp_err   = resp_err_q;
    assign resp_found = resp_found_q;
    assign resp_index = resp_index_q;
    assign resp_entry = resp_entry_q;

    // Next state and TLB port drive; ports are only touched during EXEC.
    always_comb begin
        state_nx     = state;
        req_ready    = 1'b0;
        s1_own       = 1'b0;
        s1_vppn      = '0;
        s1_asid      = '0;
        invtlb_valid = 1'b0;
        invtlb_op    = '0;
        we           = 1'b0;
        w_index      = '0;
        w_bus        = '0;
        r_index      = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                state_nx = ST_RESP;
                if (!op_illegal) begin
                    case (op_q)
                        OP_SRCH: begin
                            s1_own  = 1'b1;
                            s1_vppn = vppn_q;
                            s1_asid = asid_q;
                        end
                        OP_RD: r_index = idx_q;
                        OP_WR: begin
                            we      = 1'b1;
                            w_index = idx_q;
                            w_bus   = w_bus_full;
                        end
                        OP_FILL: begin
                            we      = 1'b1;
                            w_index = fill_idx_q;
                            w_bus   = w_bus_full;
                        end
                        OP_INV: begin
                            s1_own       = 1'b1;
                            s1_vppn      = inv_vppn_q;
                            s1_asid      = inv_asid_q;
                            invtlb_valid = 1'b1;
                            invtlb_op    = inv_op_q;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RESP: begin
                if (resp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl with a small behavioural TLB behind the ports and a
// scoreboard of expected responses.
module tb_tlb_op_ctrl;
    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    localparam logic [31:0] ELO0 = 32'h000ABC53; // ppn ABC, G=1, MAT=1, D=1, V=1
    localparam logic [31:0] ELO1 = 32'h000ABD13; // ppn ABD, G=0, MAT=1, D=1, V=1

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic            req_valid = 1'b0, req_ready;
    logic [2:0]      req_op = '0;
    logic [4:0]      req_inv_op = '0;
    logic [9:0]      req_inv_asid = '0;
    logic [31:0]     req_inv_va = '0;
    logic [31:0]     csr_tlbidx = '0;
    logic [18:0]     csr_tlbehi_vppn = '0;
    logic [9:0]      csr_asid = '0;
    logic [31:0]     csr_tlbelo0 = '0, csr_tlbelo1 = '0;
    logic            csr_refill = 1'b0;
    logic            s1_own, s1_va_bit12, s1_found;
    logic [18:0]     s1_vppn;
    logic [9:0]      s1_asid;
    logic [IDXW-1:0] s1_index;
    logic            invtlb_valid;
    logic [4:0]      invtlb_op;
    logic            we;
    logic [IDXW-1:0] w_index, r_index, resp_index;
    logic [88:0]     w_bus, r_bus, resp_entry;
    logic            resp_valid, resp_ready = 1'b1, resp_err, resp_found;
    logic [2:0]      resp_op;

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid), .req_inv_va(req_inv_va),
        .csr_tlbidx(csr_tlbidx), .csr_tlbehi_vppn(csr_tlbehi_vppn), .csr_asid(csr_asid),
        .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1), .csr_refill(csr_refill),
        .s1_own(s1_own), .s1_vppn(s1_vppn), .s1_asid(s1_asid), .s1_va_bit12(s1_va_bit12),
        .s1_found(s1_found), .s1_index(s1_index),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .we(we), .w_index(w_index), .w_bus(w_bus),
        .r_index(r_index), .r_bus(r_bus),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
        .resp_err(resp_err), .resp_found(resp_found), .resp_index(resp_index),
        .resp_entry(resp_entry)
    );

    // Behavioural TLB: entry layout e[88] vppn[87:69] ps[68:63] asid[62:53] g[52] lo0 lo1
    logic [88:0] tlb_mem [TLBNUM];
    int we_edges = 0;
    initial for (int i = 0; i < TLBNUM; i++) tlb_mem[i] = '0;
    always @(posedge clk) if (we) begin
        tlb_mem[w_index] <= w_bus;
        we_edges <= we_edges + 1;
    end
    always_comb begin
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = 0; i < TLBNUM; i++)
            if (tlb_mem[i][88] && tlb_mem[i][87:69] == s1_vppn &&
                (tlb_mem[i][52] || tlb_mem[i][62:53] == s1_asid)) begin
                s1_found = 1'b1;
                s1_index = i[IDXW-1:0];
            end
    end
    assign r_bus = tlb_mem[r_index];

    // Reference fill counter: 0 after reset, +1 per clock.
    logic [IDXW-1:0] cnt_m;
    always @(posedge clk or negedge resetn)
        if (!resetn) cnt_m <= '0;
        else         cnt_m <= cnt_m + 1'b1;

    typedef struct {
        logic [2:0]      op;
        logic            err;
        logic            found;
        logic [IDXW-1:0] index;
        logic [88:0]     entry;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass = 0;
    logic [88:0] wr_entry;

    function automatic logic [88:0] mk_entry(input logic e, input logic [18:0] vppn,
            input logic [5:0] ps, input logic [9:0] asid, input logic [31:0] l0, input logic [31:0] l1);
        logic [25:0] f0, f1;
        f0 = {l0[27:8], l0[3:2], l0[5:4], l0[1], l0[0]};
        f1 = {l1[27:8], l1[3:2], l1[5:4], l1[1], l1[0]};
        return {e, vppn, ps, asid, l0[6] & l1[6], f0, f1};
    endfunction

    function automatic exp_t mk_exp(input logic [2:0] op, input logic err, input logic found,
            input logic [IDXW-1:0] index, input logic [88:0] entry);
        exp_t e;
        e.op = op; e.err = err; e.found = found; e.index = index; e.entry = entry;
        return e;
    endfunction

    // Present a request in IDLE, return #1 after the accept edge (DUT in EXEC).
    // Inputs are scrambled afterwards so the DUT must rely on its latched copies.
    task automatic issue(input logic [2:0] op, input logic [4:0] iop, input logic [9:0] iasid,
            input logic [31:0] iva, input logic [31:0] idx, input logic [18:0] vppn,
            input logic [9:0] asid, input logic rf);
        req_op = op; req_inv_op = iop; req_inv_asid = iasid; req_inv_va = iva;
        csr_tlbidx = idx; csr_tlbehi_vppn = vppn; csr_asid = asid;
        csr_tlbelo0 = ELO0; csr_tlbelo1 = ELO1; csr_refill = rf;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = 3'($urandom); req_inv_op = 5'($urandom); req_inv_asid = 10'($urandom);
        req_inv_va = $urandom; csr_tlbidx = $urandom; csr_tlbehi_vppn = 19'($urandom);
        csr_asid = 10'($urandom); csr_tlbelo0 = $urandom; csr_tlbelo1 = $urandom;
        csr_refill = 1'($urandom);
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_cnt(input logic [IDXW-1:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cnt_m == target) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b exp 1", req_ready); else n_pass++;
        n_checks++; if (we !== 1'b0) $display("FAIL rst_we got %b exp 0", we); else n_pass++;
        n_checks++; if (s1_own !== 1'b0) $display("FAIL rst_s1_own got %b exp 0", s1_own); else n_pass++;
        n_checks++; if (invtlb_valid !== 1'b0) $display("FAIL rst_invtlb got %b exp 0", invtlb_valid); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", resp_valid); else n_pass++;
        n_checks++; if (w_bus !== 89'd0) $display("FAIL rst_w_bus got %h exp 0", w_bus); else n_pass++;
        n_checks++; if (resp_entry !== 89'd0) $display("FAIL rst_resp_entry got %h exp 0", resp_entry); else n_pass++;
        resetn = 1'b1;
    endtask

`ifdef TLB_FILL_LFSR_EN
    task automatic test_fill_lfsr();
        logic [15:0] seed;
        exp_t e;
        bit ok;
        seed = 16'hACE1;
        sb.push_back(mk_exp(3'd3, 1'b0, 1'b0, '0, '0));
        issue(3'd3, 5'd0, 10'd0, 32'd0, 32'h8C00_0000, 19'h0BEEF, 10'd9, 1'b1);
        n_checks++; if (w_index !== seed[IDXW-1:0]) $display("FAIL lfsr_w_index got %0d exp %0d", w_index, seed[IDXW-1:0]); else n_pass++;
        @(posedge clk); #1;
        wait_resp(ok);
        n_checks++; if (!ok) $display("FAIL lfsr_resp_timeout"); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (resp_err !== e.err) $display("FAIL lfsr_err got %b exp %b", resp_err, e.err); else n_pass++;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_wr();
        exp_t e;
        bit ok;
        wr_entry = mk_entry(1'b1, 19'h12345, 6'd12, 10'd3, ELO0, ELO1);
        sb.push_back(mk_exp(3'd2, 1'b0, 1'b0, '0, '0));
        issue(3'd2, 5'd0, 10'd0, 32'd0, 32'h0C00_0005, 19'h12345, 10'd3, 1'b0);
        n_checks++; if (we !== 1'b1) $display("FAIL wr_we got %b exp 1", we); else n_pass++;
        n_checks++; if (w_index !== 4'd5) $display("FAIL wr_w_index got %0d exp 5", w_index); else n_pass++;
        n_checks++; if (w_bus !== wr_entry) $display("FAIL wr_w_bus got %h exp %h", w_bus, wr_entry); else n_pass++;
        n_checks++; if (invtlb_valid !== 1'b0 || s1_own !== 1'b0) $display("FAIL wr_other_ports got inv %b own %b exp 0 0", invtlb_valid, s1_own); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (we !== 1'b0) $display("FAIL wr_we_one_cycle got %b exp 0", we); else n_pass++;
        wait_resp(ok);
        n_checks++; if (!ok) $display("FAIL wr_resp_timeout"); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (resp_op !== e.op || resp_err !== e.err) $display("FAIL wr_resp got op %0d err %b exp op %0d err %b", resp_op, resp_err, e.op, e.err); else n_pass++;
        n_checks++; if (resp_entry !== e.entry) $display("FAIL wr_resp_entry got %h exp %h", resp_entry, e.entry); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_rd();
        exp_t e;
        bit ok;
        sb.push_back(mk_exp(3'd1, 1'b0, 1'b1, 4'd5, wr_entry));
        issue(3'd1, 5'd0, 10'd0, 32'd0, 32'h0000_0005, 19'h0, 10'd0, 1'b0);
        n_checks++; if (r_index !== 4'd5) $display("FAIL rd_r_index got %0d exp 5", r_index); else n_pass++;
        n_checks++; if (we !== 1'b0) $display("FAIL rd_we got %b exp 0", we); else n_pass++;
        @(posedge clk); #1;
        wait_resp(ok);
        n_checks++; if (!ok) $display("FAIL rd_resp_timeout"); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (resp_op !== e.op || resp_err !== e.err) $display("FAIL rd_resp got op %0d err %b exp op %0d err %b", resp_op, resp_err, e.op, e.err); else n_pass++;
        n_checks++; if (resp_found !== e.found) $display("FAIL rd_found got %b exp %b", resp_found, e.found); else n_pass++;
        n_checks++; if (resp_entry !== e.entry) $display("FAIL rd_entry got %h exp %h", resp_entry, e.entry); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_srch();
        exp_t e;
        bit ok;
        logic [18:0] keys [2];
        keys[0] = 19'h12345;
        keys[1] = 19'h12346;
        sb.push_back(mk_exp(3'd0, 1'b0, 1'b1, 4'd5, '0));
        sb.push_back(mk_exp(3'd0, 1'b0, 1'b0, 4'd0, '0));
        for (int k = 0; k < 2; k++) begin
            issue(3'd0, 5'd0, 10'd0, 32'd0, 32'd0, keys[k], 10'd3, 1'b0);
            n_checks++; if (s1_own !== 1'b1 || s1_vppn !== keys[k] || s1_asid !== 10'd3)
                $display("FAIL srch%0d_key got own %b vppn %h asid %0d exp 1 %h 3", k, s1_own, s1_vppn, s1_asid, keys[k]); else n_pass++;
            n_checks++; if (s1_va_bit12 !== 1'b0) $display("FAIL srch%0d_va12 got %b exp 0", k, s1_va_bit12); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (s1_own !== 1'b0) $display("FAIL srch%0d_own_release got %b exp 0", k, s1_own); else n_pass++;
            wait_resp(ok);
            n_checks++; if (!ok) $display("FAIL srch%0d_resp_timeout", k); else n_pass++;
            e = sb.pop_front();
            n_checks++; if (resp_found !== e.found) $display("FAIL srch%0d_found got %b exp %b", k, resp_found, e.found); else n_pass++;
            if (e.found) begin
                n_checks++; if (resp_index !== e.index) $display("FAIL srch%0d_index got %0d exp %0d", k, resp_index, e.index); else n_pass++;
            end
            n_checks++; if (resp_entry !== e.entry || resp_err !== e.err) $display("FAIL srch%0d_entry_err got %h %b exp %h %b", k, resp_entry, resp_err, e.entry, e.err); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_inv();
        exp_t e;
        bit ok;
        sb.push_back(mk_exp(3'd4, 1'b0, 1'b0, '0, '0));
        issue(3'd4, 5'd5, 10'd3, 32'h2468_A000, 32'd0, 19'h0, 10'd0, 1'b0);
        n_checks++; if (invtlb_valid !== 1'b1 || invtlb_op !== 5'd5) $display("FAIL inv_pulse got v %b op %0d exp 1 5", invtlb_valid, invtlb_op); else n_pass++;
        n_checks++; if (s1_own !== 1'b1 || s1_vppn !== 19'h12345 || s1_asid !== 10'd3) $display("FAIL inv_key got own %b vppn %h asid %0d exp 1 12345 3", s1_own, s1_vppn, s1_asid); else n_pass++;
        n_checks++; if (we !== 1'b0) $display("FAIL inv_we got %b exp 0", we); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (invtlb_valid !== 1'b0) $display("FAIL inv_one_cycle got %b exp 0", invtlb_valid); else n_pass++;
        wait_resp(ok);
        n_checks++; if (!ok) $display("FAIL inv_resp_timeout"); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (resp_op !== e.op || resp_err !== e.err) $display("FAIL inv_resp got op %0d err %b exp op %0d err %b", resp_op, resp_err, e.op, e.err); else n_pass++;
        @(posedge clk); #1;

        sb.push_back(mk_exp(3'd4, 1'b1, 1'b0, '0, '0));
        issue(3'd4, 5'd9, 10'd3, 32'h2468_A000, 32'd0, 19'h0, 10'd0, 1'b0);
        n_checks++; if (invtlb_valid !== 1'b0 || s1_own !== 1'b0) $display("FAIL inv9_ports got v %b own %b exp 0 0", invtlb_valid, s1_own); else n_pass++;
        @(posedge clk); #1;
        wait_resp(ok);
        n_checks++; if (!ok) $display("FAIL inv9_resp_timeout"); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (resp_err !== e.err) $display("FAIL inv9_err got %b exp %b", resp_err, e.err); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal_op();
        exp_t e;
        bit ok;
        sb.push_back(mk_exp(3'd6, 1'b1, 1'b0, '0, '0));
        issue(3'd6, 5'd0, 10'd0, 32'd0, 32'h0000_0006, 19'h11111, 10'd1, 1'b0);
        n_checks++; if (we !== 1'b0 || s1_own !== 1'b0 || invtlb_valid !== 1'b0)
            $display("FAIL ill_ports got we %b own %b inv %b exp 0 0 0", we, s1_own, invtlb_valid); else n_pass++;
        @(posedge clk); #1;
        wait_resp(ok);
        n_checks++; if (!ok) $display("FAIL ill_resp_timeout"); else n_pass++;
        e = sb.pop_front();
        n_checks++; if (resp_op !== e.op || resp_err !== e.err) $display("FAIL ill_resp got op %0d err %b exp op %0d err %b", resp_op, resp_err, e.op, e.err); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit ok;
        resp_ready = 1'b0;
        sb.push_back(mk_exp(3'd1, 1'b0, 1'b1, 4'd5, wr_entry));
        issue(3'd1, 5'd0, 10'd0, 32'd0, 32'h0000_0005, 19'h0, 10'd0, 1'b0);
        @(posedge clk); #1;
        wait_resp(ok);
        n_checks++; if (!ok) $display("FAIL bp_resp_timeout"); else n_pass++;
        e = sb.pop_front();
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (resp_valid !== 1'b1) $display("FAIL bp_valid_c%0d got %b exp 1", c, resp_valid); else n_pass++;
            n_checks++; if (resp_entry !== e.entry || resp_op !== e.op) $display("FAIL bp_stable_c%0d got %h op %0d exp %h op %0d", c, resp_entry, resp_op, e.entry, e.op); else n_pass++;
            n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready_c%0d got %b exp 0", c, req_ready); else n_pass++;
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL bp_release got rdy %b valid %b exp 1 0", req_ready, resp_valid); else n_pass++;
    endtask

    task automatic test_fill_counter();
        exp_t e;
        bit ok;
        logic [IDXW-1:0] targets [2];
        logic            refills [2];
        targets[0] = 4'd7;  refills[0] = 1'b1;
        targets[1] = 4'd11; refills[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_cnt(targets[k], ok);
            n_checks++; if (!ok) $display("FAIL fill%0d_cnt_timeout", k); else n_pass++;
            sb.push_back(mk_exp(3'd3, 1'b0, 1'b0, '0, '0));
            issue(3'd3, 5'd0, 10'd0, 32'd0, 32'h8C00_0002, 19'h0AAAA, 10'd7, refills[k]);
            n_checks++; if (we !== 1'b1 || w_index !== targets[k]) $display("FAIL fill%0d_w_index got we %b idx %0d exp 1 %0d", k, we, w_index, targets[k]); else n_pass++;
            n_checks++; if (w_bus[88] !== refills[k]) $display("FAIL fill%0d_e got %b exp %b", k, w_bus[88], refills[k]); else n_pass++;
            n_checks++; if (w_bus !== mk_entry(refills[k], 19'h0AAAA, 6'd12, 10'd7, ELO0, ELO1)) $display("FAIL fill%0d_w_bus got %h", k, w_bus); else n_pass++;
            @(posedge clk); #1;
            wait_resp(ok);
            n_checks++; if (!ok) $display("FAIL fill%0d_resp_timeout", k); else n_pass++;
            e = sb.pop_front();
            n_checks++; if (resp_op !== e.op || resp_err !== e.err) $display("FAIL fill%0d_resp got op %0d err %b exp op %0d err %b", k, resp_op, resp_err, e.op, e.err); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_exec();
        int edges_before;
        edges_before = we_edges;
        issue(3'd2, 5'd0, 10'd0, 32'd0, 32'h0C00_0009, 19'h70000, 10'd4, 1'b0);
        n_checks++; if (we !== 1'b1) $display("FAIL mrst_in_exec got we %b exp 1", we); else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++; if (we !== 1'b0 || req_ready !== 1'b1) $display("FAIL mrst_async got we %b rdy %b exp 0 1", we, req_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (we_edges !== edges_before) $display("FAIL mrst_write_dropped got %0d edges exp %0d", we_edges, edges_before); else n_pass++;
        resetn = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || we !== 1'b0)
            $display("FAIL mrst_idle got rdy %b valid %b we %b exp 1 0 0", req_ready, resp_valid, we); else n_pass++;
        n_checks++; if (tlb_mem[9][88] !== 1'b0) $display("FAIL mrst_entry9 got e %b exp 0", tlb_mem[9][88]); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef TLB_FILL_LFSR_EN
        test_fill_lfsr();
`else
        @(posedge clk); #1;
`endif
        test_wr();
        test_rd();
        test_srch();
        test_inv();
        test_illegal_op();
        test_backpressure();
`ifndef TLB_FILL_LFSR_EN
        test_fill_counter();
`endif
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
